// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the IF/MEM memory port arbiter.
// The DMType word code is what IF fetches present to the memory.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  localparam logic [2:0] DM_WORD = 3'b000;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating counter of data grants made while a fetch is waiting.
// at_lim tells the arbiter that IF must win the next arbitration.
module arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_lim
);

  logic [STARVE_CNT_W-1:0] cnt;

  assign at_lim = (cnt == LIM[STARVE_CNT_W-1:0]);

  // clear wins over increment; the count never passes LIM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_lim) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and
// the load/store stage; data wins unless a fetch has been starved too long.
//
// state    | meaning
// ARB_IDLE | no access in flight, arbitrate every cycle
// ARB_IF   | fetch owns the port, waiting for mem_ready
// ARB_D    | load/store owns the port, waiting for mem_ready
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [2:0]    d_type,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_type,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  arb_state_t state_q, state_d;

  logic if_req_m;
  logic d_req_m;
  logic done;
  logic arb_en;
  logic grant_if;
  logic grant_d;
  logic at_lim;
  logic cnt_inc;
  logic cnt_clr;

  // a requester whose completion pulse is showing is not asking again yet
  assign if_req_m = if_req & ~if_valid;
  assign d_req_m  = d_req & ~d_valid;

  assign done   = (state_q != ARB_IDLE) & mem_ready;
  assign arb_en = (state_q == ARB_IDLE) | done;

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (arb_en) begin
      if (if_req_m && at_lim) begin
        grant_if = 1'b1;
      end else if (d_req_m) begin
        grant_d = 1'b1;
      end else if (if_req_m) begin
        grant_if = 1'b1;
      end
      if (grant_if) begin
        state_d = ARB_IF;
      end else if (grant_d) begin
        state_d = ARB_D;
      end else begin
        state_d = ARB_IDLE;
      end
    end
  end

  assign cnt_inc = grant_d & if_req_m;
  assign cnt_clr = grant_if | ~if_req_m;

  arb_starve_cnt #(
    .LIM (STARVE_LIM)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .at_lim (at_lim)
  );

  // memory side is driven only from registers latched at grant time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_type  <= '0;
    end else begin
      mem_req <= (state_d != ARB_IDLE);
      busy    <= (state_d != ARB_IDLE);
      if (grant_if) begin
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
        mem_type <= DM_WORD;
      end else if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_type  <= d_type;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_valid <= done & (state_q == ARB_IF);
      d_valid  <= done & (state_q == ARB_D);
      if (done && state_q == ARB_IF) begin
        if_rdata <= mem_rdata;
      end
      // stores leave the load data register untouched
      if (done && state_q == ARB_D && !mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule
